// File: rtl/timer_pkg.sv
// Shared definitions for the countdown BCD timer.
//   state_e     : controller state encoding (IDLE/SET/RUN/PAUSE)
//   bcd_time_t  : M:SS time held as three BCD digits
//   BCD_NINE/FIVE : digit reload values used on a borrow
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET   = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] mins;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_time_t;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_FIVE = 4'd5;

endpackage

// File: rtl/one_sec_tick.sv
// Prescaler producing a one-cycle tick every TICKS_PER_SEC enabled cycles.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   enable : count while high; counter is returned to 0 while low
//   tick   : high on the cycle the counter wraps (combinational from cnt_q)
module one_sec_tick #(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = '0;
    if (enable && !tick) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/countdown_bcd_timer.sv
// Microwave cooking-time register and M:SS down-counter.
//   clk, rst_n         : clock, asynchronous active-low reset
//   digit_in/valid     : keypad BCD digit shifted in from the right
//   start/stop/clear   : one-cycle control strobes
//   door_closed        : interlock; opening the door pauses a run
//   mins/sec_tens/sec_ones : registered BCD time for the display decoder
//   running            : high while counting down
//   done               : one-cycle pulse when a run reaches 0:00
module countdown_bcd_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] mins,
  output logic       running,
  output logic       done
);

  state_e    state_q, state_d;
  bcd_time_t time_q, time_d;
  logic      running_q, running_d;
  logic      done_q, done_d;
  logic      tick;
  bcd_time_t dec_time, shifted;

  // One BCD second borrow. Tens is not normalised, so 0:99 counts
  // down through 0:9x before borrowing. Never called at 0:00.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.ones != 4'd0) begin
      r.ones = t.ones - 4'd1;
    end else begin
      r.ones = BCD_NINE;
      if (t.tens != 4'd0) begin
        r.tens = t.tens - 4'd1;
      end else begin
        r.tens = BCD_FIVE;
        r.mins = t.mins - 4'd1;
      end
    end
    return r;
  endfunction

  one_sec_tick #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state_q == RUN),
    .tick   (tick)
  );

  assign dec_time = bcd_dec(time_q);
  assign shifted  = '{mins: time_q.tens, tens: time_q.ones, ones: digit_in};

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      time_d  = '0;
    end else begin
      case (state_q)
        RUN: begin
          // A tick coinciding with stop/door-open is still applied.
          if (tick) time_d = dec_time;
          if (tick && (dec_time == '0)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (stop || !door_closed) begin
            state_d = PAUSE;
          end
        end
        default: begin
          if (start && door_closed && (state_q == SET || state_q == PAUSE)) begin
            state_d = RUN;
          end else if (digit_valid && (digit_in <= BCD_NINE)) begin
            time_d  = shifted;
            state_d = (shifted == '0) ? IDLE : SET;
          end
        end
      endcase
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      time_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign mins     = time_q.mins;
  assign sec_tens = time_q.tens;
  assign sec_ones = time_q.ones;
  assign running  = running_q;
  assign done     = done_q;

endmodule

// File: tb/tb_countdown_bcd_timer.sv
// Scoreboard bench: each driven edge pushes its expected outputs; a
// negedge monitor pops and compares against the DUT.
module tb_countdown_bcd_timer;
  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] digit_in;
  logic       digit_valid, start, stop, clear, door_closed;
  logic [3:0] sec_ones, sec_tens, mins;
  logic       running, done;

  always #5 clk = ~clk;

  countdown_bcd_timer #(.TICKS_PER_SEC(TPS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .door_closed (door_closed),
    .sec_ones    (sec_ones),
    .sec_tens    (sec_tens),
    .mins        (mins),
    .running     (running),
    .done        (done)
  );

  typedef struct packed {
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
    logic       r;
    logic       d;
  } exp_t;

  exp_t  eq[$];
  string nq[$];
  exp_t  cur;
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk(input string nm, input exp_t e);
    exp_t a;
    a = '{m: mins, t: sec_tens, o: sec_ones, r: running, d: done};
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h:%0h%0h run=%0b done=%0b, expected %0h:%0h%0h run=%0b done=%0b",
               nm, a.m, a.t, a.o, a.r, a.d, e.m, e.t, e.o, e.r, e.d);
    end
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string n;
    if (eq.size() > 0) begin
      e = eq.pop_front();
      n = nq.pop_front();
      chk(n, e);
    end
  end

  // One clock edge with the currently driven inputs; cur is the
  // expected state after that edge.
  task automatic cyc(input string nm);
    @(posedge clk);
    #1;
    eq.push_back(cur);
    nq.push_back(nm);
    digit_valid = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic key(input logic [3:0] d, input logic [3:0] m, t, o);
    digit_in = d; digit_valid = 1'b1;
    cur.m = m; cur.t = t; cur.o = o;
    cyc("key");
  endtask

  // One second of running: TPS-1 unchanged edges, then the decrement.
  task automatic sec(input logic [3:0] m, t, o);
    repeat (TPS - 1) cyc("hold");
    cur.m = m; cur.t = t; cur.o = o;
    cyc("decrement");
  endtask

  task automatic go();
    start = 1'b1; cur.r = 1'b1;
    cyc("start");
  endtask

  initial begin
    rst_n = 1'b0; door_closed = 1'b1; digit_in = 4'd0;
    digit_valid = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    cur = '0;
    #12 chk("reset", '0);
    @(negedge clk) rst_n = 1'b1;

    // Entry and wrap across both digits
    key(4'd1, 0, 0, 1); key(4'd0, 0, 1, 0); key(4'd5, 1, 0, 5);
    go();
    sec(1, 0, 4); sec(1, 0, 3); sec(1, 0, 2); sec(1, 0, 1); sec(1, 0, 0);
    sec(0, 5, 9);
    clear = 1'b1; cur = '0; cyc("clear_run");

    // Asynchronous reset mid-run at 1:23
    key(4'd1, 0, 0, 1); key(4'd2, 0, 1, 2); key(4'd3, 1, 2, 3);
    go(); cyc("run");
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1 chk("async_reset", '0);
    @(negedge clk) rst_n = 1'b1;
    cur = '0;

    // Completion with one-cycle done
    key(4'd2, 0, 0, 2);
    go();
    sec(0, 0, 1);
    repeat (TPS - 1) cyc("hold");
    cur = '{m: 0, t: 0, o: 0, r: 0, d: 1}; cyc("done_set");
    cur.d = 1'b0; cyc("done_clear");
    start = 1'b1; cyc("start_at_zero");

    // Pause via door, resume
    key(4'd3, 0, 0, 3); key(4'd0, 0, 3, 0);
    go(); cyc("run"); cyc("run");
    door_closed = 1'b0; cur.r = 1'b0; cyc("door_open");
    repeat (20) cyc("frozen");
    start = 1'b1; cyc("start_door_open");
    door_closed = 1'b1; cyc("door_shut");
    go();
    sec(0, 2, 9);

    // Ignored inputs
    digit_in = 4'd7; digit_valid = 1'b1; cyc("digit_in_run");
    stop = 1'b1; cur.r = 1'b0; cyc("stop");
    digit_in = 4'hA; digit_valid = 1'b1; cyc("digit_A");
    key(4'd4, 2, 9, 4);
    go();
    sec(2, 9, 3);
    clear = 1'b1; cur = '0; cyc("clear");
    key(4'd9, 0, 0, 9); key(4'd9, 0, 9, 9);
    go();
    for (int k = 8; k >= 0; k--) sec(0, 9, 4'(k));
    sec(0, 8, 9);

    // Priority
    clear = 1'b1; cur = '0; cyc("clear");
    key(4'd2, 0, 0, 2); key(4'd0, 0, 2, 0); key(4'd0, 2, 0, 0);
    clear = 1'b1; start = 1'b1; cur = '0; cyc("clear_start");
    start = 1'b1; cyc("idle_start");
    key(4'd5, 0, 0, 5);
    go();
    repeat (TPS - 1) cyc("hold");
    stop = 1'b1; cur = '{m: 0, t: 0, o: 4, r: 0, d: 0}; cyc("stop_on_tick");
    repeat (6) cyc("paused");

    @(negedge clk); #1;
    n_tests++;
    if (eq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", eq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_bcd_timer.md
Name: countdown_bcd_timer

Overview:
- Microwave cooking-time register and down-counter.
- Digits are keyed in while idle, then the time counts down M:SS once per second while running.
- Drives sec_ones, sec_tens and mins as 4-bit BCD straight into the 7-segment decoder stage.
- Flags completion to the top-level controller.

Parameters:
TICKS_PER_SEC, 100, clk cycles per one-second decrement (100 for simulation; board value set at top level); minimum 2.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
digit_in  input  4  keypad BCD digit
digit_valid  input  1  one-cycle strobe, digit_in valid
start  input  1  one-cycle start request
stop  input  1  one-cycle pause request
clear  input  1  one-cycle clear request
door_closed  input  1  1 = door closed
sec_ones  output  4  BCD seconds units
sec_tens  output  4  BCD seconds tens
mins  output  4  BCD minutes
running  output  1  1 while counting down
done  output  1  one-cycle pulse when count reaches 0:00

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0, state IDLE, prescaler 0. Release is synchronous to the next clk edge.
- All outputs are registered. Responses appear on the clk edge that samples the request.
- States:
  - IDLE: time is 0:00.
  - SET: a nonzero time has been entered.
  - RUN: counting down.
  - PAUSE: stopped with time remaining.
- Digit entry: accepted in IDLE, SET and PAUSE only; ignored in RUN.
  - Effect: mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit_in. The old mins is discarded.
  - digit_in>9 is ignored entirely.
  - Any entry in PAUSE moves the state to SET.
  - The state becomes SET if the resulting time is nonzero, otherwise it stays or returns to IDLE.
- sec_tens may hold 6..9 after entry (e.g. 0:99 is legal). It counts down as-is, with no normalisation.
- start: accepted only from SET or PAUSE, and only with door_closed=1.
  - Goes to RUN, running=1, prescaler cleared to 0.
  - Ignored otherwise, including at time 0:00 and with the door open.
- Prescaler: counts 0..TICKS_PER_SEC-1 only in RUN and is held at 0 elsewhere.
  - The decrement fires on the cycle the count wraps.
  - So the first decrement lands TICKS_PER_SEC cycles after the start edge.
- Decrement rules (BCD):
  - If sec_ones>0: ones-1.
  - Else ones<=9, and if sec_tens>0: tens-1.
  - Else tens<=5 and mins-1.
  - Mins never underflows, because RUN exits at 0:00.
- Completion: when a decrement produces 0:00, in the same edge: state IDLE, running=0, done=1 for exactly one cycle.
- Leaving RUN for PAUSE (running=0, time frozen, prescaler reset):
  - stop=1; or
  - door_closed=0, which is sampled every cycle in RUN.
- clear: from any state, time<=0:00, state IDLE, running=0, done=0, prescaler 0.
- Priority for same-cycle events: clear > door open / stop > start > digit_valid.
  - A decrement coinciding with stop is applied, then the state pauses.
  - A decrement coinciding with clear is discarded.
- stop in IDLE or SET: no effect.

Decomposition:
- Shared package timer_pkg:
  - State encoding constants: IDLE=2'd0, SET=2'd1, RUN=2'd2, PAUSE=2'd3.
  - BCD constants: BCD_NINE=4'd9, BCD_FIVE=4'd5.
- Sub-module one_sec_tick:
  - Parameterised prescaler with inputs clk, rst_n, enable; output tick.
  - Reusable by the display blink logic.
- The BCD decrement is a function inside the main block.

Test Plan (TICKS_PER_SEC=4):
1. Reset mid-run: at 1:23, running, assert rst_n=0 between edges -> outputs 0:00 and running=0 immediately, without waiting for a clock edge.
2. Entry and wrap:
   - Key 1,0,5 -> 1:05.
   - start with door_closed=1 -> running=1; after 4 cycles 1:04.
   - Continuing: 1:00 -> 0:59, with the borrow across both digits.
3. Completion: enter 0:02, start -> after 8 cycles 0:00; done=1 for exactly 1 cycle; running=0; state IDLE.
4. Pause/resume:
   - At 0:30 running, drop door_closed -> PAUSE, time frozen over 20 cycles.
   - start with the door still open -> ignored.
   - Close the door, then start -> 0:29 exactly 4 cycles later.
5. Illegal/ignored inputs:
   - digit 4'hA -> no change.
   - digit entered during RUN -> no change.
   - start at 0:00 -> running stays 0.
   - Key 9,9 -> 0:99; run -> 0:98 ... 0:90 -> 0:89.
6. Priority: clear+start in the same cycle from SET 2:00 -> 0:00, IDLE, running=0. stop on the tick cycle -> decrement applied, then paused.
